mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive data grants allowed while an instruction request waits.
REQ-002 SHALL have parameter MAX_RETRY, default 3: RAM ERROR responses tolerated per transaction before the arbiter forces completion.
REQ-003 SHALL have port CLK  in  1  single clock, all state rising-edge.
REQ-004 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports iREN in 1, iaddr in 32: instruction read request and word address.
REQ-006 SHALL have ports iload out 32, iwait out 1: instruction read data and stall.
REQ-007 SHALL have ports dREN in 1, dWEN in 1, daddr in 32, dstore in 32: data read/write request, address, and store data.
REQ-008 SHALL have ports dload out 32, dwait out 1: data read data and stall.
REQ-009 SHALL have ports ramREN out 1, ramWEN out 1, ramaddr out 32, ramstore out 32: single-port RAM command.
REQ-010 SHALL have ports ramload in 32, ramstate in 2: RAM data and status (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR).
REQ-011 SHALL have port memerr  out  1: sticky error flag.

Function
REQ-012 SHALL implement FSM states IDLE, IACC, DACC.
REQ-013 In IDLE, if no request is pending, SHALL stay IDLE with ramREN=ramWEN=0.
REQ-014 In IDLE with a request pending, SHALL register the winner's address, store data and op at the clock edge, then move to IACC or DACC.
REQ-015 Priority SHALL be data over instruction, except when starve_cnt==STARVE_MAX and iREN=1, in which case instruction wins.
REQ-016 starve_cnt SHALL increment (saturating) on each data grant made while iREN=1.
REQ-017 starve_cnt SHALL clear on any instruction grant, and on any cycle with iREN=0.
REQ-018 dWEN and dREN both high SHALL be treated as a write.
REQ-019 In IACC/DACC, RAM outputs SHALL come from the registered values only: ramREN=1 for reads, ramWEN=1 for writes, never both.
REQ-020 Completion occurs when ramstate==ACCESS in IACC/DACC. In that cycle, the owning wait SHALL be 0, the owning load SHALL equal ramload combinationally, and the FSM SHALL return to IDLE at the next edge.
REQ-021 Minimum latency SHALL be 2 cycles from request to wait=0: 1 grant cycle plus 1 access cycle, with zero RAM wait states.
REQ-022 ramstate BUSY or FREE during access SHALL hold state and RAM outputs.
REQ-023 ramstate ERROR during access SHALL increment retry_cnt and hold the command.
REQ-024 On the ERROR at which retry_cnt reaches MAX_RETRY, SHALL force completion: owning wait=0, load=0, memerr set and held until reset.
REQ-025 retry_cnt SHALL clear when the FSM enters IDLE.
REQ-026 iwait SHALL be 1 whenever iREN=1 and an instruction completion is not occurring this cycle; otherwise 0. dwait is defined identically for dREN|dWEN.
REQ-027 Loads of the non-owning requester SHALL be 0.
REQ-028 If the owner deasserts its request mid-access, SHALL abort: RAM outputs 0 that cycle, FSM to IDLE next edge, no completion signalled.
REQ-029 Back-to-back requests SHALL incur one IDLE arbitration cycle between transactions; new requests SHALL NOT preempt an active transaction.
REQ-030 Registered address and data SHALL NOT change during an access, even if requester inputs change.

Reset
REQ-031 On nRST low, asynchronously: state=IDLE, starve_cnt=0, retry_cnt=0, memerr=0, registered address/data/op=0.
REQ-032 During reset, all RAM outputs SHALL be 0; iload=dload=0; iwait/dwait follow REQ-026 with no completion.
REQ-033 Reset asserted mid-access SHALL abandon the transaction with no completion signalled.

Verification
REQ-034 iREN=1, iaddr=0x40, RAM answers ACCESS on first access cycle with ramload=0x8C220004 -> ramREN=1, ramaddr=0x40 in cycle 2; iwait=0 and iload=0x8C220004 in cycle 2; IDLE in cycle 3.
REQ-035 iREN and dREN both held continuously at 0x0/0x100, zero-wait RAM -> 4 data grants, then 1 instruction grant, then data resumes; dwait=1 throughout the instruction access.
REQ-036 dWEN=dREN=1, daddr=0x200, dstore=0xDEADBEEF, RAM BUSY for 3 cycles then ACCESS -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF held 4 cycles; dwait=0 only on the ACCESS cycle.
REQ-037 dREN read with RAM returning ERROR 3 times -> dwait=0 and dload=0 on the 3rd ERROR; memerr=1 thereafter until nRST.
REQ-038 nRST pulsed low during DACC with ramstate=BUSY -> immediate IDLE, RAM outputs 0, no dwait=0 pulse; a request held through reset is re-granted after release.
REQ-039 iREN dropped during IACC -> RAM outputs 0 that cycle, IDLE next edge, iwait=0, iload=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction and data requests onto a single-port RAM.
// Data has priority, with a starvation limit for instruction fetch and a bounded retry count on RAM errors.
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int MAX_RETRY  = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  state_t        state;
  logic [31:0]   addr_r, store_r;
  logic          wen_r;
  logic [SW-1:0] starve_cnt;
  logic [RW-1:0] retry_cnt;

  logic        dreq, grant_i, grant_d, own_req, live, is_err, forced, done;
  logic [31:0] load;

  assign dreq    = dREN | dWEN;
  assign grant_i = iREN && (!dreq || starve_cnt == SW'(STARVE_MAX));
  assign grant_d = dreq && !grant_i;
  assign own_req = (state == IACC) ? iREN : dreq;
  // live is low in IDLE and on the abort cycle, silencing the RAM port
  assign live    = (state != IDLE) && own_req;
  assign is_err  = ramstate == 2'd3;
  assign forced  = live && is_err && retry_cnt == RW'(MAX_RETRY - 1);
  assign done    = live && (ramstate == 2'd2 || forced);
  assign load    = (ramstate == 2'd2) ? ramload : '0;

  assign ramREN   = live && !wen_r;
  assign ramWEN   = live && wen_r;
  assign ramaddr  = live ? addr_r : '0;
  assign ramstore = live ? store_r : '0;
  assign iload    = (done && state == IACC) ? load : '0;
  assign dload    = (done && state == DACC) ? load : '0;
  assign iwait    = iREN && !(done && state == IACC);
  assign dwait    = dreq && !(done && state == DACC);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      addr_r     <= '0;
      store_r    <= '0;
      wen_r      <= 1'b0;
      starve_cnt <= '0;
      retry_cnt  <= '0;
      memerr     <= 1'b0;
    end else begin
      starve_cnt <= !iREN ? '0
                  : (state == IDLE && grant_i) ? '0
                  : (state == IDLE && grant_d && starve_cnt != SW'(STARVE_MAX)) ? starve_cnt + 1'b1
                  : starve_cnt;
      if (forced) memerr <= 1'b1;
      if (state == IDLE) begin
        if (grant_i) begin
          state   <= IACC;
          addr_r  <= iaddr;
          store_r <= '0;
          wen_r   <= 1'b0;
        end else if (grant_d) begin
          state   <= DACC;
          addr_r  <= daddr;
          store_r <= dstore;
          wen_r   <= dWEN;
        end
      end else if (!own_req || done) begin
        state     <= IDLE;
        retry_cnt <= '0;
      end else if (is_err) begin
        retry_cnt <= retry_cnt + 1'b1;
      end
    end
  end
endmodule
